// File: rtl/sdlx_pkg.sv
// Shared definitions for the SDLX R-type controller: FSM states, opcode/func codes, field positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sdlx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLL = 6'h04;
  localparam logic [5:0] FN_SRL = 6'h06;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Instruction field positions (LSB of each field; widths are implied by the layout).
  localparam int OP_LSB  = 26;
  localparam int RS1_LSB = 21;
  localparam int RS2_LSB = 16;
  localparam int RD_LSB  = 11;
  localparam int FN_LSB  = 0;

endpackage

// File: rtl/sdlx_alu.sv
// Combinational R-type ALU; also reports whether func is a supported operation.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: func (6b function code), a/b (operands), result, legal_func (func is supported).
module sdlx_alu
  import sdlx_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        func,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              legal_func
);

  always_comb begin
    result     = '0;
    legal_func = 1'b1;
    case (func)
      FN_ADD: result = a + b;
      FN_SUB: result = a - b;
      FN_AND: result = a & b;
      FN_OR:  result = a | b;
      FN_XOR: result = a ^ b;
      FN_SLL: result = a << b[4:0];
      FN_SRL: result = a >> b[4:0];
      FN_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      default: legal_func = 1'b0;
    endcase
  end

endmodule

// File: rtl/sdlx_rtype_ctrl.sv
// Issue/execute/writeback controller for triadic R-type SDLX instructions in front of a register file.
// Latency: 4 cycles per instruction (IDLE accept, READ, EXEC, WB); done/rf_we high in the 4th cycle.
// Backpressure: instr_ready is high only in IDLE; instr_valid is ignored while busy.
// Ports: instr/instr_valid/instr_ready (issue), rf_rs1/rf_rs2/rf_read + rf_num1/rf_num2 (operand read),
//        rf_rd/rf_data_in/rf_we (writeback), done/illegal (retire pulse), retired_cnt (retire count).
module sdlx_rtype_ctrl
  import sdlx_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [REG_AW-1:0] rf_rs1,
  output logic [REG_AW-1:0] rf_rs2,
  output logic              rf_read,
  input  logic [DATA_W-1:0] rf_num1,
  input  logic [DATA_W-1:0] rf_num2,
  output logic [REG_AW-1:0] rf_rd,
  output logic [DATA_W-1:0] rf_data_in,
  output logic              rf_we,
  output logic              done,
  output logic              illegal,
  output logic [31:0]       retired_cnt
);

  state_t state_q, state_d;

  logic [REG_AW-1:0] rs1_q, rs2_q, rd_q;
  logic [5:0]        func_q;
  logic              op_ok_q;   // opcode was R-type
  logic              we_ok_q;   // legal and rd != R0, resolved in EXEC
  logic [DATA_W-1:0] data_q;
  logic              done_q, illegal_q;
  logic [31:0]       cnt_q;

  logic [DATA_W-1:0] alu_result;
  logic              alu_legal;
  logic              legal;
  logic              accept;

  // Shamt-style bits [10:6] carry no meaning for these instructions.
  logic unused_shamt;
  assign unused_shamt = ^instr[10:6];

  sdlx_alu #(.DATA_W(DATA_W)) u_alu (
    .func       (func_q),
    .a          (rf_num1),
    .b          (rf_num2),
    .result     (alu_result),
    .legal_func (alu_legal)
  );

  assign legal  = op_ok_q & alu_legal;
  assign accept = (state_q == ST_IDLE) & instr_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Handshake and register-file strobes decode straight from the state register,
  // so reset kills rf_we and rf_read in the same cycle it is asserted.
  always_comb begin
    state_d     = state_q;
    instr_ready = 1'b0;
    rf_read     = 1'b0;
    rf_we       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_d = ST_READ;
      end
      ST_READ: begin
        rf_read = 1'b1;
        state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_WB;
      ST_WB: begin
        rf_we   = we_ok_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      func_q    <= '0;
      op_ok_q   <= 1'b0;
      we_ok_q   <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      if (accept) begin
        rs1_q   <= instr[RS1_LSB +: REG_AW];
        rs2_q   <= instr[RS2_LSB +: REG_AW];
        rd_q    <= instr[RD_LSB +: REG_AW];
        func_q  <= instr[FN_LSB +: 6];
        op_ok_q <= (instr[OP_LSB +: 6] == OP_RTYPE);
      end
      if (state_q == ST_EXEC) begin
        data_q  <= alu_result;
        we_ok_q <= legal & (rd_q != '0);
      end
      // done/illegal are set by the EXEC closing edge so they cover exactly the WB cycle.
      done_q    <= (state_q == ST_EXEC);
      illegal_q <= (state_q == ST_EXEC) & ~legal;
      if (state_q == ST_WB) cnt_q <= cnt_q + 32'd1;
    end
  end

  assign rf_rs1      = rs1_q;
  assign rf_rs2      = rs2_q;
  assign rf_rd       = rd_q;
  assign rf_data_in  = data_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_sdlx_rtype_ctrl.sv
// Testbench for sdlx_rtype_ctrl: behavioural register file, directed table, back-to-back, random, reset-in-WB, wrap.
// Latency: n/a.
// Backpressure: n/a.
module tb_sdlx_rtype_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [4:0]  rf_rs1, rf_rs2, rf_rd;
  logic        rf_read, rf_we;
  logic [31:0] rf_num1, rf_num2, rf_data_in;
  logic        done, illegal;
  logic [31:0] retired_cnt;

  always #5 clk = ~clk;

  sdlx_rtype_ctrl #(.DATA_W(32), .REG_AW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .rf_rs1      (rf_rs1),
    .rf_rs2      (rf_rs2),
    .rf_read     (rf_read),
    .rf_num1     (rf_num1),
    .rf_num2     (rf_num2),
    .rf_rd       (rf_rd),
    .rf_data_in  (rf_data_in),
    .rf_we       (rf_we),
    .done        (done),
    .illegal     (illegal),
    .retired_cnt (retired_cnt)
  );

  // Environment register file: registered read, write on rising edge.
  logic [31:0] regs [32];
  logic        rf_init;
  always @(posedge clk) begin
    if (rf_init) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
      regs[1] <= 32'd1;
      regs[2] <= 32'd2;
      regs[3] <= 32'd3;
      regs[9] <= 32'h49;
    end else begin
      if (rf_read) begin
        rf_num1 <= regs[rf_rs1];
        rf_num2 <= regs[rf_rs2];
      end
      if (rf_we) regs[rf_rd] <= rf_data_in;
    end
  end

  // Reference architectural state, updated from the instruction semantics only.
  logic [31:0] ref_regs [32];
  logic [31:0] exp_cnt;
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc(input int op, input int rs1, input int rs2, input int rd, input int fn);
    logic [5:0] o, f;
    logic [4:0] a, b, d;
    o = op[5:0]; a = rs1[4:0]; b = rs2[4:0]; d = rd[4:0]; f = fn[5:0];
    return {o, a, b, d, 5'b0, f};
  endfunction

  // Instruction semantics straight from the ISA description.
  function automatic void model(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                                output bit legal, output logic [31:0] res);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    legal = (ins[31:26] == 6'd0);
    res   = 32'd0;
    case (ins[5:0])
      6'h20: res = a + b;
      6'h22: res = a - b;
      6'h24: res = a & b;
      6'h25: res = a | b;
      6'h26: res = a ^ b;
      6'h04: res = a << b[4:0];
      6'h06: res = a >> b[4:0];
      6'h2A: res = (sa < sb) ? 32'd1 : 32'd0;
      default: legal = 1'b0;
    endcase
  endfunction

  // Issue one instruction and check every phase of its 4-cycle sequence.
  task automatic run_instr(input logic [31:0] ins, input bit exp_we, input logic [31:0] exp_data, input bit exp_ill);
    @(negedge clk);
    chk("ready_idle", {31'd0, instr_ready}, 32'd1);
    instr = ins;
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr = $urandom;
    chk("read_strobe", {31'd0, rf_read}, 32'd1);
    chk("ready_busy", {31'd0, instr_ready}, 32'd0);
    chk("rs1", {27'd0, rf_rs1}, {27'd0, ins[25:21]});
    chk("rs2", {27'd0, rf_rs2}, {27'd0, ins[20:16]});
    @(posedge clk); #1;
    chk("exec_no_read", {31'd0, rf_read}, 32'd0);
    chk("exec_no_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    chk("wb_done", {31'd0, done}, 32'd1);
    chk("wb_illegal", {31'd0, illegal}, {31'd0, exp_ill});
    chk("wb_we", {31'd0, rf_we}, {31'd0, exp_we});
    chk("wb_rd", {27'd0, rf_rd}, {27'd0, ins[15:11]});
    if (!exp_ill) chk("wb_data", rf_data_in, exp_data);
    exp_cnt = exp_cnt + 32'd1;
    @(posedge clk); #1;
    chk("post_done", {31'd0, done}, 32'd0);
    chk("post_we", {31'd0, rf_we}, 32'd0);
    chk("retired_cnt", retired_cnt, exp_cnt);
  endtask

  task automatic run_model(input logic [31:0] ins);
    bit          legal;
    logic [31:0] res;
    bit          we;
    model(ins, ref_regs[ins[25:21]], ref_regs[ins[20:16]], legal, res);
    we = legal && (ins[15:11] != 5'd0);
    run_instr(ins, we, res, !legal);
    if (we) ref_regs[ins[15:11]] = res;
  endtask

  typedef struct {
    logic [31:0] ins;
    bit          we;
    logic [31:0] data;
    bit          ill;
  } vec_t;

  vec_t tbl [7];

  logic [5:0] legal_fns [8];

  initial begin
    logic [31:0] ins_a, ins_b;
    bit          rdy [8];
    int          hs;

    legal_fns[0] = 6'h20; legal_fns[1] = 6'h22; legal_fns[2] = 6'h24; legal_fns[3] = 6'h25;
    legal_fns[4] = 6'h26; legal_fns[5] = 6'h04; legal_fns[6] = 6'h06; legal_fns[7] = 6'h2A;

    tbl[0] = '{32'h00432820,                   1'b1, 32'd5,        1'b0}; // ADD r5,r2,r3
    tbl[1] = '{enc(0, 1, 9, 6, 6'h22),         1'b1, 32'hFFFFFFB8, 1'b0}; // SUB r6,r1,r9
    tbl[2] = '{enc(0, 1, 9, 7, 6'h2A),         1'b1, 32'd1,        1'b0}; // SLT r7,r1,r9
    tbl[3] = '{enc(0, 9, 2, 8, 6'h04),         1'b1, 32'h124,      1'b0}; // SLL r8,r9,r2
    tbl[4] = '{enc(0, 1, 2, 0, 6'h20),         1'b0, 32'd3,        1'b0}; // ADD r0,r1,r2
    tbl[5] = '{enc(8, 1, 2, 11, 6'h20),        1'b0, 32'd0,        1'b1}; // bad opcode
    tbl[6] = '{enc(0, 1, 2, 12, 6'h3F),        1'b0, 32'd0,        1'b1}; // bad func

    for (int i = 0; i < 32; i++) ref_regs[i] = 32'd0;
    ref_regs[1] = 32'd1; ref_regs[2] = 32'd2; ref_regs[3] = 32'd3; ref_regs[9] = 32'h49;
    exp_cnt = 32'd0;

    // Reset
    rst = 1'b1; rf_init = 1'b1; instr = 32'd0; instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_read", {31'd0, rf_read}, 32'd0);
    chk("rst_we", {31'd0, rf_we}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    chk("rst_cnt", retired_cnt, 32'd0);
    chk("rst_rs1", {27'd0, rf_rs1}, 32'd0);
    chk("rst_rd", {27'd0, rf_rd}, 32'd0);
    chk("rst_data", rf_data_in, 32'd0);
    rst = 1'b0; rf_init = 1'b0;

    // Directed table
    for (int i = 0; i < 7; i++) begin
      run_instr(tbl[i].ins, tbl[i].we, tbl[i].data, tbl[i].ill);
      if (tbl[i].we) ref_regs[tbl[i].ins[15:11]] = tbl[i].data;
    end
    chk("r5_written", regs[5], 32'd5);
    chk("r0_untouched", regs[0], 32'd0);
    chk("r11_untouched", regs[11], 32'd0);

    // Back-to-back with instr_valid held: ADD r4,r1,r2 then ADD r5,r4,r4
    ins_a = enc(0, 1, 2, 4, 6'h20);
    ins_b = enc(0, 4, 4, 5, 6'h20);
    hs = 0;
    instr = ins_a;
    instr_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rdy[i] = instr_ready;
      if (instr_ready) begin
        instr = (hs == 0) ? ins_a : ins_b;
        hs++;
      end
    end
    @(negedge clk);
    instr_valid = 1'b0;
    for (int i = 0; i < 8; i++)
      chk("b2b_ready_pattern", {31'd0, rdy[i]}, {31'd0, (i % 4) == 0});
    ref_regs[4] = 32'd3;
    ref_regs[5] = 32'd6;
    exp_cnt = exp_cnt + 32'd2;
    chk("b2b_r4", regs[4], 32'd3);
    chk("b2b_r5", regs[5], 32'd6);
    chk("b2b_cnt", retired_cnt, exp_cnt);

    // Random instructions against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ins;
      ins = $urandom;
      if ($urandom_range(0, 5) != 0) ins[31:26] = 6'd0;
      if ($urandom_range(0, 5) != 0) ins[5:0] = legal_fns[$urandom_range(0, 7)];
      run_model(ins);
    end
    for (int i = 0; i < 32; i++) chk("regfile_vs_model", regs[i], ref_regs[i]);

    // Reset asserted during WB drops the write
    @(negedge clk);
    instr = enc(0, 1, 2, 10, 6'h20);
    instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("wbrst_we_before", {31'd0, rf_we}, 32'd1);
    rst = 1'b1;
    #1;
    chk("wbrst_we_drop", {31'd0, rf_we}, 32'd0);
    chk("wbrst_done_drop", {31'd0, done}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = 32'd0;
    chk("wbrst_ready", {31'd0, instr_ready}, 32'd1);
    chk("wbrst_r10_kept", regs[10], ref_regs[10]);
    chk("wbrst_cnt", retired_cnt, exp_cnt);

    // Counter wrap
    @(negedge clk);
    force dut.cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.cnt_q;
    exp_cnt = 32'hFFFFFFFF;
    chk("wrap_preload", retired_cnt, exp_cnt);
    run_model(enc(0, 3, 3, 13, 6'h25));
    chk("wrap_zero", retired_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sdlx_rtype_ctrl.md
Name: sdlx_rtype_ctrl

Overview:
- Multi-cycle issue/execute/writeback controller for triadic R-type SDLX instructions. It sits directly upstream of the register file.
- Accepts one 32-bit instruction over a valid/ready handshake and drives the register file's read port (RS1, RS2, read).
- Consumes the register file's registered operands (num1, num2), computes the ALU result, and writes it back through the register file's write port (rd, data_in, WE).
- Strictly sequential, so there are no data hazards. Throughput is one instruction per 4 cycles.

Parameters:
- DATA_W, 32, datapath and instruction width.
- REG_AW, 5, register index width (32 registers).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr  in  DATA_W  instruction word, sampled at handshake.
- instr_valid  in  1  instruction available.
- instr_ready  out  1  controller can accept (IDLE only).
- rf_rs1  out  REG_AW  to register file RS1.
- rf_rs2  out  REG_AW  to register file RS2.
- rf_read  out  1  to register file read.
- rf_num1  in  DATA_W  from register file num1; valid the cycle after rf_read.
- rf_num2  in  DATA_W  from register file num2.
- rf_rd  out  REG_AW  to register file rd.
- rf_data_in  out  DATA_W  writeback data.
- rf_we  out  1  to register file WE.
- done  out  1  one-cycle pulse, instruction retired.
- illegal  out  1  qualifies done: instruction was illegal, no write.
- retired_cnt  out  32  count of retired instructions, legal and illegal.

Behaviour:
- Reset (async, immediate):
  - state=IDLE.
  - All registered outputs go to 0: rf_rs1, rf_rs2, rf_rd, rf_data_in, done, illegal, retired_cnt.
  - rf_read=0 and rf_we=0 immediately on reset assertion.
  - Reset during WB drops the write. Reset during any state discards the instruction.
- Instruction format: op=[31:26], rs1=[25:21], rs2=[20:16], rd=[15:11], func=[5:0]. Bits [10:6] are ignored.
- Legal only when op==0 and func is one of:
  - ADD 0x20: rs1+rs2, mod 2^32.
  - SUB 0x22: rs1-rs2, mod 2^32.
  - AND 0x24, OR 0x25, XOR 0x26: bitwise.
  - SLL 0x04: rs1 << rs2[4:0].
  - SRL 0x06: logical rs1 >> rs2[4:0].
  - SLT 0x2A: signed rs1<rs2 gives 1, else 0.
- FSM states: IDLE, READ, EXEC, WB. State-decoded outputs are combinational from the state register.
- IDLE:
  - instr_ready=1.
  - When instr_valid is high at an edge: latch instr, decode fields and legality into registers, go to READ.
- READ (1 cycle):
  - rf_read=1, rf_rs1/rf_rs2 driven from the latched fields.
  - The register file captures operands at the closing edge. Go to EXEC.
- EXEC (1 cycle):
  - rf_num1/rf_num2 are valid. The ALU result is registered into rf_data_in at the closing edge.
  - Go to WB.
- WB (1 cycle):
  - rf_rd=rd.
  - rf_we=1 only if legal and rd!=0; R0 is never written.
  - done=1. illegal=1 if the instruction was illegal.
  - retired_cnt increments at the closing edge and wraps 0xFFFFFFFF to 0.
  - Go to IDLE.
- Latency: handshake at edge E0. done and rf_we are high in the cycle between E2 and E3; the register write takes effect at E3. The earliest next handshake is at E3, so its read sees the new value.
- instr_ready is 0 in READ, EXEC and WB. instr_valid is ignored there and instr is don't-care.
- Illegal instructions still go through the full 4-cycle sequence (READ is harmless), with rf_we=0.

Decomposition:
- Package sdlx_pkg: FSM state enum; opcode/func localparams (OP_RTYPE, FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_SLL, FN_SRL, FN_SLT); field bit positions.
- One combinational sub-module, sdlx_alu (func, a, b -> result, legal_func), instantiated in EXEC. The FSM, field registers and counter stay in the top.

Test Plan:
- Reset, then ADD r5,r2,r3 (instr 0x00432820) with bench regfile R2=2, R3=3:
  - read at cycle+1; rf_we, rf_rd=5, rf_data_in=5, done in the 4th cycle.
  - retired_cnt=1.
- SUB r6,r1,r9 with R1=1, R9=0x49 gives 0xFFFFFFB8.
- SLT r7,r1,r9 with the same values gives 1.
- SLL r8,r9,r2 with R9=0x49, R2=2 gives 0x124.
- rd=0 (ADD r0,r1,r2): done=1, illegal=0, rf_we stays 0.
- op=0x08 or func=0x3F: done=1, illegal=1, rf_we=0, count increments.
- Back-to-back with instr_valid held high:
  - ADD r4,r1,r2 then ADD r5,r4,r4 gives r5=6, proving write-before-read.
  - instr_ready is low for exactly 3 of every 4 cycles.
- Assert rst during WB:
  - rf_we drops the same cycle; the register is not written; state is IDLE and instr_ready=1 after release.
- Preload retired_cnt path via 2^32 forced value (or a force) at 0xFFFFFFFF, retire one instruction: counter reads 0.
